// File: rtl/packet_receiver.sv
// rtl/packet_receiver.sv - packet loader: header/payload words to a banked buffer write port, plus solver launch handshake
module packet_receiver #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              intrpt,
  input  logic              cmd,
  input  logic [31:0]       dataBus,
  output logic              done,
  output logic              wr_en,
  output logic [3:0]        wr_bank,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              start_proc,
  input  logic              proc_done,
  output logic              busy,
  output logic              err,
  output logic [15:0]       pkt_count
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PAYLOAD = 2'd1,
    S_PROC    = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic                r_done;
  logic                r_wr_en;
  logic [3:0]          r_wr_bank;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [31:0]         r_wr_data;
  logic                r_start_proc;
  logic                r_busy;
  logic                r_err;
  logic [15:0]         r_pkt_count;
  logic [3:0]          r_bank;
  logic [ADDR_W-1:0]   r_base;
  logic [ADDR_W-1:0]   r_len;
  logic [ADDR_W-1:0]   r_idx;

  logic                w_done_nxt;
  logic                w_wr_en_nxt;
  logic [3:0]          w_wr_bank_nxt;
  logic [ADDR_W-1:0]   w_wr_addr_nxt;
  logic [31:0]         w_wr_data_nxt;
  logic                w_start_proc_nxt;
  logic                w_busy_nxt;
  logic                w_err_nxt;
  logic [15:0]         w_pkt_count_nxt;
  logic [3:0]          w_bank_nxt;
  logic [ADDR_W-1:0]   w_base_nxt;
  logic [ADDR_W-1:0]   w_len_nxt;
  logic [ADDR_W-1:0]   w_idx_nxt;

  logic [3:0]          w_hdr_bank;
  logic [ADDR_W-1:0]   w_hdr_base;
  logic [ADDR_W-1:0]   w_hdr_len;
  logic                w_capture;
  logic                w_proc_req;
  logic                w_trunc;
  logic                w_last_word;

  // Header layout: bank in the top nibble, base from bit 16 up, length from bit 0 up.
  assign w_hdr_bank  = dataBus[31:28];
  assign w_hdr_base  = dataBus[16+ADDR_W-1:16];
  assign w_hdr_len   = dataBus[ADDR_W-1:0];

  // Gating on r_done keeps the word still held during the ack cycle from being taken twice.
  assign w_capture   = intrpt && cmd && !r_done &&
                       ((r_state == S_IDLE) || (r_state == S_PAYLOAD));
  assign w_proc_req  = intrpt && !cmd && !r_done && (r_state == S_IDLE);
  assign w_trunc     = intrpt && !cmd && (r_state == S_PAYLOAD);
  assign w_last_word = (r_idx == (r_len - ADDR_W'(1)));

  always_comb begin
    w_state_nxt      = r_state;
    w_done_nxt       = w_capture;
    w_wr_en_nxt      = 1'b0;
    w_wr_bank_nxt    = r_wr_bank;
    w_wr_addr_nxt    = r_wr_addr;
    w_wr_data_nxt    = r_wr_data;
    w_start_proc_nxt = 1'b0;
    w_err_nxt        = r_err;
    w_pkt_count_nxt  = r_pkt_count;
    w_bank_nxt       = r_bank;
    w_base_nxt       = r_base;
    w_len_nxt        = r_len;
    w_idx_nxt        = r_idx;

    if (proc_done && (r_state != S_PROC)) begin
      w_err_nxt = 1'b1;
    end

    case (r_state)
      S_IDLE: begin
        if (w_capture) begin
          if (w_hdr_len == '0) begin
            w_pkt_count_nxt = r_pkt_count + 16'd1;
          end else begin
            w_bank_nxt  = w_hdr_bank;
            w_base_nxt  = w_hdr_base;
            w_len_nxt   = w_hdr_len;
            w_idx_nxt   = '0;
            w_state_nxt = S_PAYLOAD;
          end
        end else if (w_proc_req) begin
          w_start_proc_nxt = 1'b1;
          w_state_nxt      = S_PROC;
        end
      end

      S_PAYLOAD: begin
        if (w_capture) begin
          w_wr_en_nxt   = 1'b1;
          w_wr_bank_nxt = r_bank;
          w_wr_addr_nxt = r_base + r_idx;
          w_wr_data_nxt = dataBus;
          w_idx_nxt     = r_idx + ADDR_W'(1);
          if (w_last_word) begin
            w_pkt_count_nxt = r_pkt_count + 16'd1;
            w_state_nxt     = S_IDLE;
          end
        end else if (w_trunc) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end

      S_PROC: begin
        if (proc_done) begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt == S_PROC);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_done       <= 1'b0;
      r_wr_en      <= 1'b0;
      r_wr_bank    <= '0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_start_proc <= 1'b0;
      r_busy       <= 1'b0;
      r_err        <= 1'b0;
      r_pkt_count  <= '0;
      r_bank       <= '0;
      r_base       <= '0;
      r_len        <= '0;
      r_idx        <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_done       <= w_done_nxt;
      r_wr_en      <= w_wr_en_nxt;
      r_wr_bank    <= w_wr_bank_nxt;
      r_wr_addr    <= w_wr_addr_nxt;
      r_wr_data    <= w_wr_data_nxt;
      r_start_proc <= w_start_proc_nxt;
      r_busy       <= w_busy_nxt;
      r_err        <= w_err_nxt;
      r_pkt_count  <= w_pkt_count_nxt;
      r_bank       <= w_bank_nxt;
      r_base       <= w_base_nxt;
      r_len        <= w_len_nxt;
      r_idx        <= w_idx_nxt;
    end
  end

  assign done       = r_done;
  assign wr_en      = r_wr_en;
  assign wr_bank    = r_wr_bank;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign start_proc = r_start_proc;
  assign busy       = r_busy;
  assign err        = r_err;
  assign pkt_count  = r_pkt_count;

endmodule
